// File: rtl/cs_pkg.sv
// cs_pkg: shared definitions for the cyclic-shift stream encoder.
// State encodings, the shift-table entry type and a width-generic rotate helper.
// Optional feature macro used by the encoder: CS_ENC_FRAME_CNT_EN.
package cs_pkg;

    // Encoder states, kept as plain constants so legacy tools can consume them.
    typedef logic [0:0] cs_state_t;
    localparam cs_state_t S_DATA = 1'b0;
    localparam cs_state_t S_PAR  = 1'b1;

    // Default width of one shift-table entry.
    localparam int CS_SHIFT_W = 4;
    typedef logic [CS_SHIFT_W-1:0] cs_shift_t;

    // Widest symbol the rotate helper supports; callers truncate to their own width.
    localparam int CS_MAX_W = 64;
    localparam int CS_IDX_W = $clog2(CS_MAX_W);

    // Rotate the low w bits of x left by (s mod w). Bit i moves to bit (i+s) mod w,
    // which is the same as {x[w-1-s:0], x[w-1:w-s]}. Bits at and above w return 0.
    // The width is an argument rather than a type parameter so one function serves
    // every symbol width from 1 to CS_MAX_W.
    function automatic logic [CS_MAX_W-1:0] cs_rotl(input logic [CS_MAX_W-1:0] x,
                                                    input int s,
                                                    input int w);
        logic [CS_MAX_W-1:0] r;
        int                  amt;
        int                  dst;
        r   = '0;
        amt = s % w;
        for (int i = 0; i < CS_MAX_W; i++) begin
            if (i < w) begin
                dst = i + amt;
                if (dst >= w) begin
                    dst = dst - w;
                end
                r[dst[CS_IDX_W-1:0]] = x[i[CS_IDX_W-1:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cs_rot_xor.sv
// cs_rot_xor: one parity-row update term. Rotates the incoming data symbol by the
// row's table entry (mod WIDTH) and XORs it into that row's running accumulator.
// Purely combinational; the encoder instantiates one per parity row.
module cs_rot_xor
    import cs_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int SHIFT_W = CS_SHIFT_W
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHIFT_W-1:0] shift,
    output logic [WIDTH-1:0]   acc_next
);

    logic [WIDTH-1:0] rotated;

    // Fold the rotated symbol into the accumulator.
    // NOTE: every signal written here is assigned on every pass through the block,
    // so no storage (latch) can be inferred for it.
    always_comb begin
        rotated  = WIDTH'(cs_rotl(CS_MAX_W'(in_data), int'(shift), WIDTH));
        acc_next = acc ^ rotated;
    end

endmodule

// File: rtl/cs_stream_encoder.sv
// cs_stream_encoder: symbol-serial cyclic-shift MDS encoder with valid/ready on both
// sides. Each frame takes M data symbols and emits K coded symbols: the M data symbols
// unchanged, then K-M parity symbols. Parity row p is the XOR of every data symbol d
// rotated left by table[p][d] mod WIDTH; the table is written through the cfg port
// only while no frame is in flight.
// Optional feature: define CS_ENC_FRAME_CNT_EN to add a 16-bit frame_cnt output that
// counts frames whose last parity symbol has been accepted downstream.
module cs_stream_encoder
    import cs_pkg::*;
#(
    parameter  int M       = 4,
    parameter  int K       = 6,
    parameter  int WIDTH   = 6,
    parameter  int SHIFT_W = CS_SHIFT_W,
    localparam int P       = K - M,
    localparam int PIDX_W  = (P > 1) ? $clog2(P) : 1,
    localparam int DIDX_W  = $clog2(M),
    localparam int IDX_W   = $clog2(K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               cfg_we,
    input  logic [PIDX_W-1:0]  cfg_pidx,
    input  logic [DIDX_W-1:0]  cfg_didx,
    input  logic [SHIFT_W-1:0] cfg_shift,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last
`ifdef CS_ENC_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    cs_state_t          state;
    logic [DIDX_W-1:0]  d_cnt;
    logic [PIDX_W-1:0]  p_cnt;
    logic [WIDTH-1:0]   acc      [P];
    logic [WIDTH-1:0]   acc_next [P];
    logic [SHIFT_W-1:0] tbl      [P][M];

    logic slot_free;
    logic in_fire;
    logic par_load;
    logic data_final;
    logic par_final;
    logic pidx_ok;
    logic didx_ok;
    logic cfg_ok;

    // ------------------------------------------------------------------
    // Handshake and control decode
    // ------------------------------------------------------------------
    // The output register can take a new symbol when it is empty or being drained.
    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = (state == S_DATA) && slot_free;
    assign in_fire    = in_valid && in_ready;
    assign par_load   = (state == S_PAR) && slot_free;
    assign data_final = (d_cnt == DIDX_W'(M - 1));
    assign par_final  = (p_cnt == PIDX_W'(P - 1));

    // A frame is in flight from its first accepted symbol until its last parity
    // symbol has left the output register; the table must not move under it.
    assign busy = (state == S_PAR) || (d_cnt != '0) || (out_valid && out_last);

    // Index range checks only exist where the index field can encode too much.
    if ((1 << PIDX_W) > P) begin : g_pidx_chk
        assign pidx_ok = (cfg_pidx < PIDX_W'(P));
    end else begin : g_pidx_full
        assign pidx_ok = 1'b1;
    end

    if ((1 << DIDX_W) > M) begin : g_didx_chk
        assign didx_ok = (cfg_didx < DIDX_W'(M));
    end else begin : g_didx_full
        assign didx_ok = 1'b1;
    end

    // A write landing on the same edge as a data handshake would race the
    // accumulator update, so it is dropped along with writes during a frame.
    assign cfg_ok = cfg_we && !busy && !in_fire && pidx_ok && didx_ok;

    // ------------------------------------------------------------------
    // Per-row rotate/XOR terms for the symbol currently on in_data
    // ------------------------------------------------------------------
    for (genvar p = 0; p < P; p++) begin : g_row
        cs_rot_xor #(
            .WIDTH   (WIDTH),
            .SHIFT_W (SHIFT_W)
        ) u_rot_xor (
            .acc      (acc[p]),
            .in_data  (in_data),
            .shift    (tbl[p][d_cnt]),
            .acc_next (acc_next[p])
        );
    end

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    // Output register: data symbols pass straight through, parity symbols follow.
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the values from before the edge, independent of block or statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_idx   <= IDX_W'(d_cnt);
            out_last  <= 1'b0;
        end else if (par_load) begin
            out_valid <= 1'b1;
            out_data  <= acc[p_cnt];
            out_idx   <= IDX_W'(M) + IDX_W'(p_cnt);
            out_last  <= par_final;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Frame sequencing: count data symbols in, then parity symbols out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_DATA;
            d_cnt <= '0;
            p_cnt <= '0;
        end else if (in_fire) begin
            if (data_final) begin
                d_cnt <= '0;
                state <= S_PAR;
            end else begin
                d_cnt <= d_cnt + DIDX_W'(1);
            end
        end else if (par_load) begin
            if (par_final) begin
                p_cnt <= '0;
                state <= S_DATA;
            end else begin
                p_cnt <= p_cnt + PIDX_W'(1);
            end
        end
    end

    // Parity accumulators: absorb each accepted data symbol, clear once the
    // final parity of the frame has been handed to the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < P; p++) begin
                acc[p] <= '0;
            end
        end else if (in_fire) begin
            for (int p = 0; p < P; p++) begin
                acc[p] <= acc_next[p];
            end
        end else if (par_load && par_final) begin
            for (int p = 0; p < P; p++) begin
                acc[p] <= '0;
            end
        end
    end

    // Shift table: written only between frames.
    // NOTE: this table is built from flops, not a RAM macro, and the encoder must
    // come out of reset with a known all-zero table, so it is reset explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < P; p++) begin
                for (int d = 0; d < M; d++) begin
                    tbl[p][d] <= '0;
                end
            end
        end else if (cfg_ok) begin
            tbl[cfg_pidx][cfg_didx] <= cfg_shift;
        end
    end

`ifdef CS_ENC_FRAME_CNT_EN
    // Frame counter: one count per frame whose last symbol is accepted; wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (out_valid && out_ready && out_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/cs_stream_encoder.md
Name: cs_stream_encoder

Overview:
- Symbol-serial, handshaked successor to the parallel cyclic-shift MDS encoder.
- Accepts M data symbols one per beat over valid/ready and emits K coded symbols one per beat: M systematic, then K-M parity.
- Parity is built by accumulating rotated data symbols with XOR, using a shift table programmed at run time through a config port.
- Sits between the packetiser and the link framer, where full backpressure is needed.

Parameters:
- M, 4, data symbols per frame (>=2)
- K, 6, coded symbols per frame (K>M)
- WIDTH, 6, bits per symbol
- SHIFT_W, 4, width of one shift-table entry; rotation amount = entry mod WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  data symbol valid
- in_ready  out  1  encoder can accept a data symbol
- in_data  in  WIDTH  data symbol
- cfg_we  in  1  shift-table write strobe
- cfg_pidx  in  $clog2(K-M) (min 1)  parity row
- cfg_didx  in  $clog2(M)  data column
- cfg_shift  in  SHIFT_W  shift value
- busy  out  1  frame in progress; config writes ignored
- out_valid  out  1  coded symbol valid (registered)
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  coded symbol (registered)
- out_idx  out  $clog2(K)  position 0..K-1 of out_data in the frame
- out_last  out  1  out_idx==K-1

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, state=S_DATA, d_cnt=0, p_cnt=0, all accumulators=0, all table entries=0.
- Reset mid-frame discards the partial frame. The first symbol after reset is data index 0.
- Output register: loads when slot_free = !out_valid || out_ready. out_valid clears when out_ready is high and no new load occurs.
- Latency: an accepted input appears on out_data on the next cycle.
- State S_DATA:
  - in_ready = slot_free.
  - On in_valid&&in_ready: out_data<=in_data, out_idx<=d_cnt.
  - For every p: acc[p] ^= rotl(in_data, table[p][d_cnt] mod WIDTH).
  - d_cnt increments. When d_cnt==M-1: d_cnt<=0, go to S_PAR.
- State S_PAR:
  - in_ready=0.
  - When slot_free: out_data<=acc[p_cnt], out_idx<=M+p_cnt, out_last<=(p_cnt==K-M-1), p_cnt increments.
  - On the final parity load: p_cnt<=0, clear all accumulators, go to S_DATA.
- Back-to-back frames: the next frame may be accepted while the final parity is still held in the output register. There are no bubbles under continuous out_ready, so throughput is K output beats per frame.
- Rotation: rotl(x,s) = {x[WIDTH-1-s:0], x[WIDTH-1:WIDTH-s]}; s=0 is identity.
- Busy: busy = (state==S_PAR) || (d_cnt!=0) || (out_valid&&out_last).
- Config write:
  - A write to table[cfg_pidx][cfg_didx] takes effect next cycle only if !busy and no input handshake occurs this cycle; otherwise it is silently dropped.
  - Out-of-range indices are dropped.
- Holding: out_data, out_idx and out_last hold stable while out_valid && !out_ready.
- in_data is don't-care when in_valid=0, and the accumulators must not change.

Optional Feature:
- Macro: CS_ENC_FRAME_CNT_EN.
- When defined: extra output frame_cnt [15:0]. Reset 0; increments on each out_last handshake; wraps 0xFFFF->0.
- When undefined: port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package cs_pkg holds:
  - state enum (S_DATA, S_PAR)
  - typedef for one shift entry, logic [SHIFT_W-1:0]
  - function cs_rotl(x, s) generic in WIDTH via a parameterised class or macro
- Sub-module cs_rot_xor: combinational, one instance per parity row. Inputs acc, in_data, shift; output acc ^ rotl(in_data, shift mod WIDTH).

Test Plan:
- Basic frame (WIDTH=4, M=2, K=3, table[0]={0,1}, out_ready=1): inputs 0x3, 0x5 -> outputs 0x3 (idx0), 0x5 (idx1), 0x9 (idx2, last).
- Backpressure (same config): out_ready low for 3 cycles while out_valid holding 0x5 -> in_ready=0, out_data stays 0x5. After release, parity 0x9 follows with no loss or duplication.
- Back-to-back frames: inputs 0x3,0x5,0x1,0x2 with continuous valid/ready -> 0x3,0x5,0x9,0x1,0x2,0x5 on consecutive cycles; accumulator cleared between frames.
- Config while busy: write table[0][1]=2 after the first symbol is accepted -> dropped, frame parity uses shift 1. Same write when idle -> next frame 0x3,0x5 gives parity 0x3^0x5=0x6.
- Reset mid-frame: rst after the first data symbol -> all outputs 0 next cycle, table zeroed. The next inputs 0x7,0x1 give parity 0x6 (shifts 0).
- Default config (M=4, K=6, WIDTH=6) with CS_ENC_FRAME_CNT_EN defined: 3 frames with random data -> frame_cnt=3; parities match the software model.
